// File: rtl/pdp8_trace_if.sv
// Trace-monitor bus: CPU observation signals, host controls and the
// record/flag outputs that a host-side reader drains.
interface pdp8_trace_if #(
    parameter int AW = 6,
    parameter int CW = 32
);
    logic [3:0]    state;
    logic [11:0]   pc;
    logic [11:0]   ir;
    logic [11:0]   ac;
    logic          l;
    logic          ion;
    logic [2:0]    if_f;
    logic [2:0]    df_f;
    logic          trace_all;
    logic [CW-1:0] max_cycles;
    logic          clear;
    logic          rd_en;
    logic [44:0]   rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic [CW-1:0] cycles;
    logic          limit_hit;
    logic          halted;
    logic [11:0]   halt_pc;

    // Host / CPU side: drives observations and controls, reads results.
    modport master (
        output state, pc, ir, ac, l, ion, if_f, df_f,
        output trace_all, max_cycles, clear, rd_en,
        input  rd_data, empty, full, count, overflow,
        input  cycles, limit_hit, halted, halt_pc
    );

    // Trace monitor side.
    modport slave (
        input  state, pc, ir, ac, l, ion, if_f, df_f,
        input  trace_all, max_cycles, clear, rd_en,
        output rd_data, empty, full, count, overflow,
        output cycles, limit_hit, halted, halt_pc
    );
endinterface

// File: rtl/pdp8_trace.sv
// pdp8 execution-trace monitor: counts instruction fetches, captures
// per-instruction records (every fetch or every Nth) into a FWFT FIFO,
// and reports fetch-limit and HALT conditions with sticky flags.
module pdp8_trace #(
    parameter int SAMPLE_INTERVAL = 5000,
    parameter int AW              = 6,
    parameter int CW              = 32
) (
    input  logic         clk,
    input  logic         reset,
    pdp8_trace_if.slave  bus
);
    localparam int            DEPTH        = 1 << AW;
    localparam logic [3:0]    ST_F0        = 4'b0000;
    localparam logic [3:0]    ST_HALT      = 4'b1100;
    localparam logic [3:0]    ST_NONE      = 4'b1111;
    localparam logic [AW:0]   LP_DEPTH     = {1'b1, {AW{1'b0}}};
    localparam logic [CW-1:0] LP_SAMP_LAST = CW'(SAMPLE_INTERVAL - 1);

    logic [3:0]    r_prev_state;
    logic [CW-1:0] r_cycles;
    logic [CW-1:0] r_samp;
    logic          r_limit_hit;
    logic          r_halted;
    logic [11:0]   r_halt_pc;
    logic          r_overflow;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [44:0]   r_mem [DEPTH];

    logic          w_active;
    logic          w_fetch;
    logic          w_cap_fetch;
    logic          w_halt_ev;
    logic          w_sample_hit;
    logic [CW-1:0] w_samp_nxt;
    logic [CW-1:0] w_cycles_nxt;
    logic          w_limit_nxt;
    logic          w_push_req;
    logic [44:0]   w_rec;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    // Event detection; clear suppresses every event in its cycle.
    assign w_active     = !r_halted && !r_limit_hit;
    assign w_fetch      = (bus.state == ST_F0) && (r_prev_state != ST_F0);
    assign w_cap_fetch  = w_fetch && w_active && !bus.clear;
    assign w_halt_ev    = (bus.state == ST_HALT) && w_active && !bus.clear;

    // Sampling: the counter wraps on the Nth fetch, which is the one sampled.
    assign w_sample_hit = (r_samp == LP_SAMP_LAST);
    assign w_samp_nxt   = w_sample_hit ? '0 : r_samp + 1'b1;
    assign w_cycles_nxt = (&r_cycles) ? r_cycles : r_cycles + 1'b1;
    assign w_limit_nxt  = (bus.max_cycles != '0) && (w_cycles_nxt >= bus.max_cycles);

    // Record assembly; fetch and HALT are mutually exclusive states.
    assign w_push_req   = (w_cap_fetch && (bus.trace_all || w_sample_hit)) || w_halt_ev;
    assign w_rec        = {w_halt_ev, bus.ion, bus.if_f, bus.df_f, bus.l,
                           bus.ac, bus.ir, bus.pc};

    // FIFO handshake: a push into a full FIFO succeeds only alongside a pop.
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == LP_DEPTH);
    assign w_pop        = bus.rd_en && !w_empty && !bus.clear;
    assign w_push       = w_push_req && (!w_full || w_pop);

    // Track the previous major state so a multi-cycle F0 counts once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_state <= ST_NONE;
        end else begin
            r_prev_state <= bus.state;
        end
    end

    // Fetch counter, sample counter, limit and halt flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycles    <= '0;
            r_samp      <= '0;
            r_limit_hit <= 1'b0;
            r_halted    <= 1'b0;
            r_halt_pc   <= '0;
        end else if (bus.clear) begin
            r_cycles    <= '0;
            r_samp      <= '0;
            r_limit_hit <= 1'b0;
            r_halted    <= 1'b0;
            r_halt_pc   <= '0;
        end else begin
            if (w_cap_fetch) begin
                r_cycles <= w_cycles_nxt;
                r_samp   <= w_samp_nxt;
                if (w_limit_nxt) begin
                    r_limit_hit <= 1'b1;
                end
            end
            if (w_halt_ev) begin
                r_halted  <= 1'b1;
                r_halt_pc <= bus.pc;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Record storage; contents need no reset since empty gates the reader.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_rec;
        end
    end

    assign bus.rd_data   = r_mem[r_rptr];
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.cycles    = r_cycles;
    assign bus.limit_hit = r_limit_hit;
    assign bus.halted    = r_halted;
    assign bus.halt_pc   = r_halt_pc;
endmodule

// File: tb/tb_pdp8_trace.sv
// Scoreboard bench for pdp8_trace: directed scenarios plus randomized
// CPU state traffic, checked against a fetch-index based reference model.
module tb_pdp8_trace;
    localparam int SI    = 4;
    localparam int AW    = 2;
    localparam int CW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pdp8_trace_if #(.AW(AW), .CW(CW)) bus ();

    pdp8_trace #(.SAMPLE_INTERVAL(SI), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          n_popped = 0;
    logic [44:0] exp_q[$];

    // Reference model state
    int          m_occ;
    int          m_fetch_n;
    int          m_cycles;
    bit          m_limit;
    bit          m_halted;
    bit          m_ovf;
    logic [11:0] m_halt_pc;
    logic [3:0]  m_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_occ = 0; m_fetch_n = 0; m_cycles = 0;
        m_limit = 0; m_halted = 0; m_ovf = 0; m_halt_pc = '0;
        exp_q.delete();
    endtask

    // Predicts the effect of the coming clock edge from the current inputs.
    task automatic model_step();
        bit fetch, active, pop, req;
        logic [44:0] rec;
        if (bus.clear) begin
            model_clear();
            m_prev = bus.state;
            return;
        end
        fetch  = (bus.state == 4'h0) && (m_prev != 4'h0);
        active = !m_halted && !m_limit;
        pop    = bus.rd_en && (m_occ > 0);
        req    = 0;
        rec    = '0;
        if (fetch && active) begin
            m_fetch_n++;
            if (m_cycles < CMAX) m_cycles++;
            if (bus.trace_all || (m_fetch_n % SI == 0)) begin
                req = 1;
                rec = {1'b0, bus.ion, bus.if_f, bus.df_f, bus.l, bus.ac, bus.ir, bus.pc};
            end
            if (bus.max_cycles != 0 && m_cycles >= int'(bus.max_cycles)) m_limit = 1;
        end else if (bus.state == 4'hC && active) begin
            m_halted  = 1;
            m_halt_pc = bus.pc;
            req = 1;
            rec = {1'b1, bus.ion, bus.if_f, bus.df_f, bus.l, bus.ac, bus.ir, bus.pc};
        end
        if (req) begin
            if (m_occ < DEPTH || pop) begin
                exp_q.push_back(rec);
                m_occ++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) m_occ--;
        m_prev = bus.state;
    endtask

    task automatic cyc(input logic [3:0] st, input logic [11:0] p, input bit re);
        bus.state  = st;
        bus.pc     = p;
        bus.ir     = 12'($urandom);
        bus.ac     = 12'($urandom);
        bus.l      = 1'($urandom);
        bus.ion    = 1'($urandom);
        bus.if_f   = 3'($urandom);
        bus.df_f   = 3'($urandom);
        bus.rd_en  = re;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [11:0] p, input bit re);
        cyc(4'h0, p, re);
        cyc(4'h1, p + 12'd1, re);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        cyc(4'h1, 12'd0, 1'b0);
        bus.clear = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_count"},    64'(bus.count),     64'(m_occ));
        chk({tag, "_empty"},    64'(bus.empty),     64'(m_occ == 0));
        chk({tag, "_full"},     64'(bus.full),      64'(m_occ == DEPTH));
        chk({tag, "_overflow"}, 64'(bus.overflow),  64'(m_ovf));
        chk({tag, "_cycles"},   64'(bus.cycles),    64'(m_cycles));
        chk({tag, "_limit"},    64'(bus.limit_hit), 64'(m_limit));
        chk({tag, "_halted"},   64'(bus.halted),    64'(m_halted));
        chk({tag, "_halt_pc"},  64'(bus.halt_pc),   64'(m_halt_pc));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_count"},    64'(bus.count),     64'd0);
        chk({tag, "_empty"},    64'(bus.empty),     64'd1);
        chk({tag, "_full"},     64'(bus.full),      64'd0);
        chk({tag, "_overflow"}, 64'(bus.overflow),  64'd0);
        chk({tag, "_cycles"},   64'(bus.cycles),    64'd0);
        chk({tag, "_limit"},    64'(bus.limit_hit), 64'd0);
        chk({tag, "_halted"},   64'(bus.halted),    64'd0);
        chk({tag, "_halt_pc"},  64'(bus.halt_pc),   64'd0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && m_occ > 0; i++) cyc(4'h1, 12'd0, 1'b1);
        bus.rd_en = 1'b0;
        chk({tag, "_drain_empty"}, 64'(bus.empty), 64'd1);
        chk({tag, "_drain_left"},  64'(exp_q.size()), 64'd0);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        bus.rd_en = 1'b0;
        bus.clear = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_clear();
        m_prev = 4'hF;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: whenever the reader pops a record, compare it with the scoreboard head.
    always @(negedge clk) begin
        if (!reset && !bus.clear && bus.rd_en && !bus.empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual=%0h required=none", bus.rd_data);
            end else begin
                chk("record", 64'(bus.rd_data), 64'(exp_q.pop_front()));
                n_popped++;
            end
        end
    end

    initial begin
        int n0;
        logic [3:0] st;
        int r;
        bit re;

        reset = 1'b1;
        bus.state = 4'h1; bus.pc = '0; bus.ir = '0; bus.ac = '0;
        bus.l = 0; bus.ion = 0; bus.if_f = '0; bus.df_f = '0;
        bus.trace_all = 1'b1; bus.max_cycles = '0;
        bus.clear = 1'b0; bus.rd_en = 1'b0;
        model_clear();
        m_prev = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;

        // Four single-cycle fetches, every one traced, read back in order.
        bus.trace_all = 1'b1;
        for (int i = 0; i < 4; i++) fetch(12'o200 + 12'(i), 1'b0);
        chk("t1_count", 64'(bus.count), 64'd4);
        chk("t1_cycles", 64'(bus.cycles), 64'd4);
        n0 = n_popped;
        drain("t1");
        chk("t1_pops", 64'(n_popped - n0), 64'd4);

        // F0 held for three cycles is one fetch.
        do_clear();
        cyc(4'h0, 12'o1000, 1'b0);
        cyc(4'h0, 12'o1000, 1'b0);
        cyc(4'h0, 12'o1000, 1'b0);
        cyc(4'h2, 12'o1001, 1'b0);
        chk("t2_cycles", 64'(bus.cycles), 64'd1);
        chk("t2_count", 64'(bus.count), 64'd1);
        drain("t2");

        // Sampled mode: every 4th fetch is recorded.
        do_clear();
        bus.trace_all = 1'b0;
        for (int i = 1; i <= 12; i++) fetch(12'o2000 + 12'(i), 1'b0);
        chk("t3_count", 64'(bus.count), 64'd3);
        chk("t3_cycles", 64'(bus.cycles), 64'd12);
        n0 = n_popped;
        drain("t3");
        chk("t3_pops", 64'(n_popped - n0), 64'd3);

        // Overflow on a full FIFO, then simultaneous push and pop when full.
        do_clear();
        bus.trace_all = 1'b1;
        for (int i = 0; i < 6; i++) fetch(12'o3000 + 12'(i), 1'b0);
        chk("t4_full", 64'(bus.full), 64'd1);
        chk("t4_count", 64'(bus.count), 64'd4);
        chk("t4_overflow", 64'(bus.overflow), 64'd1);
        cyc(4'h0, 12'o3100, 1'b1);
        chk("t4_pushpop_count", 64'(bus.count), 64'd4);
        cyc(4'h1, 12'o3101, 1'b0);
        check_outputs("t4");
        drain("t4");

        // Fetch limit of 5 with continuous draining, then clear.
        do_clear();
        bus.max_cycles = 8'd5;
        n0 = n_popped;
        for (int i = 1; i <= 10; i++) begin
            cyc(4'h0, 12'o4000 + 12'(i), 1'b1);
            if (i == 4) chk("t5_limit_before", 64'(bus.limit_hit), 64'd0);
            if (i == 5) chk("t5_limit_at", 64'(bus.limit_hit), 64'd1);
            cyc(4'h1, 12'o4400 + 12'(i), 1'b1);
        end
        chk("t5_cycles", 64'(bus.cycles), 64'd5);
        drain("t5");
        chk("t5_pops", 64'(n_popped - n0), 64'd5);
        do_clear();
        check_reset_values("t5_clear");
        bus.max_cycles = '0;

        // HALT detection with later fetches ignored.
        bus.trace_all = 1'b0;
        fetch(12'o5000, 1'b0);
        fetch(12'o5001, 1'b0);
        cyc(4'hC, 12'o7601, 1'b0);
        chk("t6_halted", 64'(bus.halted), 64'd1);
        chk("t6_halt_pc", 64'(bus.halt_pc), 64'o7601);
        chk("t6_count", 64'(bus.count), 64'd1);
        chk("t6_halt_bit", 64'(bus.rd_data[44]), 64'd1);
        cyc(4'hC, 12'o7602, 1'b0);
        for (int i = 0; i < 4; i++) fetch(12'o5100 + 12'(i), 1'b0);
        chk("t6_cycles_frozen", 64'(bus.cycles), 64'd2);
        check_outputs("t6");
        drain("t6");

        // Asynchronous reset in the middle of traffic.
        do_clear();
        bus.trace_all = 1'b1;
        for (int i = 0; i < 3; i++) fetch(12'o6000 + 12'(i), 1'b0);
        async_reset();
        fetch(12'o6100, 1'b0);
        chk("t7_count", 64'(bus.count), 64'd1);
        chk("t7_cycles", 64'(bus.cycles), 64'd1);
        drain("t7");

        // Fetch counter saturation.
        do_clear();
        bus.trace_all = 1'b0;
        for (int i = 0; i < 260; i++) fetch(12'(i), 1'b1);
        chk("t8_cycles_sat", 64'(bus.cycles), 64'(CMAX));
        check_outputs("t8");
        drain("t8");

        // Randomized traffic phases.
        for (int ph = 0; ph < 4; ph++) begin
            do_clear();
            bus.trace_all = 1'($urandom);
            bus.max_cycles = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 60));
            for (int i = 0; i < 300; i++) begin
                r = $urandom_range(0, 199);
                if (r < 80)       st = 4'h0;
                else if (r == 199) st = 4'hC;
                else              st = 4'($urandom_range(1, 11));
                re = ($urandom_range(0, 2) == 0);
                cyc(st, 12'($urandom), re);
            end
            bus.rd_en = 1'b0;
            check_outputs("rand");
            drain("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pdp8_trace.md
Name: pdp8_trace

Overview:
Hardware execution-trace monitor for the pdp8 CPU. It watches the CPU major-state bus and architectural registers, counts instruction fetches, and captures per-instruction records into an on-chip FIFO. Records are captured on every fetch or on every Nth fetch. It also provides a fetch-count limit and halt detection. It sits beside the CPU and pdp8_io. A host-side reader drains it, giving synthesizable equivalents of the simulation-only PC display, cycle limit and HALTED reporting.

Parameters:
SAMPLE_INTERVAL, 5000, fetches between sampled records when trace_all=0; legal range 1..2^CW-1.
AW, 6, FIFO address width; depth = 2^AW records.
CW, 32, width of fetch counter and max_cycles.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
state  in  4  CPU major state (F0=4'b0000 … E3=4'b1011, HALT=4'b1100)
pc  in  12  CPU program counter
ir  in  12  CPU mb/instruction register
ac  in  12  accumulator
l  in  1  link
ion  in  1  interrupt enable
if_f  in  3  instruction field
df_f  in  3  data field
trace_all  in  1  1 = capture every fetch; 0 = sampled
max_cycles  in  CW  fetch limit; 0 = unlimited
clear  in  1  synchronous clear of counters, flags and FIFO
rd_en  in  1  pop head record
rd_data  out  45  head record {halt, ion, if_f, df_f, l, ac, ir, pc}, first-word fall-through
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  AW+1  records held
overflow  out  1  sticky: a record was dropped because FIFO was full
cycles  out  CW  fetch events counted
limit_hit  out  1  sticky: fetch limit reached
halted  out  1  sticky: HALT state seen
halt_pc  out  12  pc latched on first HALT

Behaviour:
- Reset (async): FIFO pointers 0, empty=1, full=0, count=0, overflow=0, cycles=0, limit_hit=0, halted=0, halt_pc=0, sample counter=0, prev_state=4'b1111. rd_data is don't-care while empty.
- Fetch event: state==F0 and prev_state!=F0, where prev_state is registered each clock. A multi-cycle F0 counts once.
- Monitor is active when !halted && !limit_hit.
- On a fetch event while active:
  - cycles increments, saturating at all-ones.
  - Sample counter increments. When it equals SAMPLE_INTERVAL-1 it wraps to 0 and asserts sample_hit.
  - If trace_all || sample_hit, push record with halt bit=0 and the register values sampled at this edge.
  - If max_cycles!=0 and the new cycles value >= max_cycles, set limit_hit in the same cycle. The record of that fetch is still pushed.
- HALT: the first clock with state==4'b1100 while active sets halted and latches halt_pc=pc. It also pushes one record with halt bit=1, regardless of trace_all or sampling.
- While halted or limit_hit: no counting, no captures. Flags hold until clear or reset.
- FIFO:
  - A push when full drops the record and sets overflow. A push and pop in the same cycle when full both succeed.
  - A pop when empty is ignored, with no pointer change.
  - count = pushes − pops, range 0..2^AW.
  - Pointers wrap modulo 2^AW; full/empty are derived from count.
- clear has priority over all events in its cycle and yields the reset state, except prev_state, which keeps tracking the state bus.
- Latency: a record appears at rd_data/!empty one clock after the capturing edge.

Test Plan:
- trace_all=1, drive 4 F0 pulses (pc=0200..0203, one cycle each, with non-F0 states between) -> count=4, cycles=4, pops return pc 0200,0201,0202,0203 in order, halt bit 0.
- F0 held 3 consecutive cycles -> cycles=1, one record.
- trace_all=0, SAMPLE_INTERVAL=4, 12 fetches -> 3 records, taken at fetches 4, 8 and 12.
- AW=2, trace_all=1, 6 fetches without pop -> full=1, count=4, overflow=1, records = first 4 pcs. Then rd_en plus a fetch in the same cycle -> count stays 4.
- max_cycles=5, 10 fetches -> limit_hit after the 5th, cycles=5, 5 records. clear -> all outputs return to reset values.
- state=4'b1100 with pc=7601 -> halted=1, halt_pc=7601, final record halt bit=1. Later fetches are ignored. Assert reset mid-run -> flags and FIFO cleared immediately.
